accum_bank: RTL and testbench

- Parametrised multi-channel accumulator bank, the next generation of the single-bit value accumulator feeding the LED outputs in main.
- Accepts tagged add requests over a valid/ready handshake and accumulates each into one of CHANNELS registers of WIDTH bits.
- Per-channel wrap or saturate mode, sticky overflow flags, and a sequenced clear sweep.
- Drives per-channel LED bits and a result stream toward the top level.

---
 rtl/accum_pkg.sv | 24 ++
 rtl/accum_lane.sv | 79 +++++++
 rtl/accum_bank.sv | 209 ++++++++++++++++++++
 tb/tb_accum_bank.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Shared definitions for the accumulator bank:
//   - bank_state_e : sweep FSM states (IDLE, CLEAR)
//   - MODE_WRAP / MODE_SAT : values accepted by the SATURATE parameter
//   - calc_ch_w()  : channel-index width, never narrower than one bit
// -----------------------------------------------------------------------------
package accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bank_state_e;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // A single-channel bank still needs a one-bit index port, so the width is
  // clamped at 1 rather than using $clog2(1) = 0.
  function automatic int unsigned calc_ch_w(input int unsigned channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// -----------------------------------------------------------------------------
// accum_lane
// One accumulator channel: adds an unsigned operand to its register, either
// wrapping or clamping on carry-out, keeps a sticky overflow flag, and reloads
// START_VALUE when told to clear.
//
// Ports:
//   clock     in   system clock
//   rstn      in   asynchronous active-low reset
//   add_en    in   add add_data into the accumulator on this edge
//   add_data  in   [WIDTH-1:0] unsigned addend
//   clr_en    in   reload START_VALUE and drop the overflow flag on this edge
//   acc       out  [WIDTH-1:0] current accumulator value
//   acc_next  out  [WIDTH-1:0] value the accumulator will hold after this edge
//   ovf       out  sticky overflow flag
// -----------------------------------------------------------------------------
module accum_lane
  import accum_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] START_VALUE = '0,
  parameter int unsigned      SATURATE    = MODE_WRAP
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             add_en,
  input  logic [WIDTH-1:0] add_data,
  input  logic             clr_en,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_next,
  output logic             ovf
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
  logic             carry;

  // NOTE: every signal assigned in a combinational block gets a default at the
  // top, so no path through the if/else leaves it unassigned (no latch).
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    // One extra bit so the carry out of the add is visible.
    sum   = {1'b0, acc_q} + {1'b0, add_data};
    carry = sum[WIDTH];

    if (clr_en) begin
      acc_d = START_VALUE;
      ovf_d = 1'b0;
    end else if (add_en) begin
      if ((SATURATE == MODE_SAT) && carry) begin
        acc_d = '1;
      end else begin
        acc_d = sum[WIDTH-1:0];
      end
      ovf_d = ovf_q | carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process evaluation order.
  // NOTE: the accumulator is a plain register with an async reset, unlike a
  // RAM; it must come out of reset at START_VALUE without a clear sweep.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      acc_q <= START_VALUE;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc      = acc_q;
  assign acc_next = acc_d;
  assign ovf      = ovf_q;

endmodule

// File: rtl/accum_bank.sv
// -----------------------------------------------------------------------------
// accum_bank
// Multi-channel accumulator bank. Tagged add requests arrive over a
// valid/ready handshake, sit for one cycle in a stage-1 register, then update
// the addressed lane and produce a result beat one cycle after acceptance.
// A clear pulse starts a sweep that reloads one lane per cycle.
//
// Ports:
//   clock      in   system clock
//   rstn       in   asynchronous active-low reset
//   in_valid   in   add request valid
//   in_ready   out  request accepted on this edge when in_valid is also high
//   in_chan    in   [CH_W-1:0] target channel
//   in_data    in   [WIDTH-1:0] unsigned addend
//   clear      in   single-cycle pulse that starts the clear sweep
//   out_valid  out  one-cycle pulse per completed add
//   out_chan   out  [CH_W-1:0] channel just updated
//   out_sum    out  [WIDTH-1:0] new value of that channel
//   err        out  one-cycle pulse for an accepted request to a missing channel
//   ovf        out  [CHANNELS-1:0] sticky per-channel overflow flags
//   led        out  [CHANNELS-1:0] MSB of each accumulator
//   busy       out  high while the clear sweep runs
// -----------------------------------------------------------------------------
module accum_bank
  import accum_pkg::*;
#(
  parameter  int unsigned CHANNELS    = 4,
  parameter  int unsigned WIDTH       = 8,
  parameter  int unsigned START_VALUE = 0,
  parameter  int unsigned SATURATE    = MODE_WRAP,
  localparam int unsigned CH_W        = calc_ch_w(CHANNELS)
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_chan,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                clear,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_chan,
  output logic [WIDTH-1:0]    out_sum,
  output logic                err,
  output logic [CHANNELS-1:0] ovf,
  output logic [CHANNELS-1:0] led,
  output logic                busy
);

  localparam logic [WIDTH-1:0] START_TRUNC = WIDTH'(START_VALUE);
  localparam logic [CH_W-1:0]  K_LAST      = CH_W'(CHANNELS - 1);
  // One bit wider than the index so CHANNELS = 2^CH_W is representable.
  localparam logic [CH_W:0]    CHAN_LIMIT  = (CH_W + 1)'(CHANNELS);

  // ---------------------------------------------------------------------------
  // Clear-sweep FSM
  // ---------------------------------------------------------------------------
  bank_state_e     state_q, state_d;
  logic [CH_W-1:0] k_q, k_d;
  logic            sweep_on;

  // Flips to 1 on the first edge after reset release; holds in_ready low
  // while reset is asserted.
  logic            ready_en_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      k_q        <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          k_d     = '0;
        end
      end
      CLEAR: begin
        // A clear pulse arriving here is ignored; the sweep just runs out.
        if (k_q == K_LAST) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + CH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  logic [CHANNELS-1:0] lane_clr;

  always_comb begin
    sweep_on = (state_q == CLEAR);
    busy     = sweep_on;
    // No beat is taken in the clear cycle itself, so nothing is left in
    // stage 1 once the sweep is running.
    in_ready = ready_en_q && (state_q == IDLE) && !clear;
    lane_clr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lane_clr[i] = sweep_on && (k_q == CH_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 and result registers
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]  s1_chan_q,  s1_chan_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic             chan_ok;

  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_chan_q,  out_chan_d;
  logic [WIDTH-1:0] out_sum_q,   out_sum_d;
  logic             err_q,       err_d;

  logic [WIDTH-1:0]    lane_acc  [CHANNELS];
  logic [WIDTH-1:0]    lane_next [CHANNELS];
  logic [CHANNELS-1:0] lane_add;
  logic [WIDTH-1:0]    sel_next;

  always_comb begin
    accept     = in_valid && in_ready;
    s1_valid_d = accept;
    s1_chan_d  = accept ? in_chan : s1_chan_q;
    s1_data_d  = accept ? in_data : s1_data_q;

    chan_ok    = ({1'b0, s1_chan_q} < CHAN_LIMIT);

    // Decode only real lanes; an out-of-range index matches none of them, so
    // no accumulator moves. The lane reads its live register, which is why
    // back-to-back beats to one channel need no forwarding.
    lane_add = '0;
    sel_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s1_chan_q == CH_W'(i)) begin
        lane_add[i] = s1_valid_q;
        sel_next    = lane_next[i];
      end
    end

    out_valid_d = s1_valid_q && chan_ok;
    err_d       = s1_valid_q && !chan_ok;
    out_chan_d  = out_valid_d ? s1_chan_q : out_chan_q;
    out_sum_d   = out_valid_d ? sel_next  : out_sum_q;
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_chan_q   <= '0;
      s1_data_q   <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_sum_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_chan_q   <= s1_chan_d;
      s1_data_q   <= s1_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_sum_q   <= out_sum_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_sum   = out_sum_q;
  assign err       = err_q;

  // ---------------------------------------------------------------------------
  // Lanes
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    accum_lane #(
      .WIDTH       (WIDTH),
      .START_VALUE (START_TRUNC),
      .SATURATE    (SATURATE)
    ) u_lane (
      .clock    (clock),
      .rstn     (rstn),
      .add_en   (lane_add[i]),
      .add_data (s1_data_q),
      .clr_en   (lane_clr[i]),
      .acc      (lane_acc[i]),
      .acc_next (lane_next[i]),
      .ovf      (ovf[i])
    );

    assign led[i] = lane_acc[i][WIDTH-1];
  end

endmodule

// File: tb/tb_accum_bank.sv
// -----------------------------------------------------------------------------
// tb_accum_bank
// Three bank instances share clock and reset:
//   dut 0 : 4 channels, wrap,     START_VALUE 0
//   dut 1 : 4 channels, saturate, START_VALUE 0
//   dut 2 : 3 channels, wrap,     START_VALUE 0x105 (truncates to 0x05)
// Stimulus pushes the expected result beat (with its due cycle) into a
// per-instance queue; a negedge monitor pops and compares every output beat.
// -----------------------------------------------------------------------------
module tb_accum_bank;

  localparam int NDUT = 3;

  logic clock = 1'b0;
  logic rstn;
  always #5 clock = ~clock;

  logic       in_valid  [NDUT];
  logic [1:0] in_chan   [NDUT];
  logic [7:0] in_data   [NDUT];
  logic       clear     [NDUT];
  logic       in_ready  [NDUT];
  logic       out_valid [NDUT];
  logic [1:0] out_chan  [NDUT];
  logic [7:0] out_sum   [NDUT];
  logic       err       [NDUT];
  logic       busy      [NDUT];

  logic [3:0] ovf_a, led_a, ovf_b, led_b;
  logic [2:0] ovf_c, led_c;

  accum_bank #(.CHANNELS(4), .WIDTH(8), .START_VALUE(0), .SATURATE(0)) u_dut_a (
    .clock(clock), .rstn(rstn),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_chan(in_chan[0]), .in_data(in_data[0]),
    .clear(clear[0]), .out_valid(out_valid[0]), .out_chan(out_chan[0]), .out_sum(out_sum[0]),
    .err(err[0]), .ovf(ovf_a), .led(led_a), .busy(busy[0])
  );

  accum_bank #(.CHANNELS(4), .WIDTH(8), .START_VALUE(0), .SATURATE(1)) u_dut_b (
    .clock(clock), .rstn(rstn),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_chan(in_chan[1]), .in_data(in_data[1]),
    .clear(clear[1]), .out_valid(out_valid[1]), .out_chan(out_chan[1]), .out_sum(out_sum[1]),
    .err(err[1]), .ovf(ovf_b), .led(led_b), .busy(busy[1])
  );

  accum_bank #(.CHANNELS(3), .WIDTH(8), .START_VALUE('h105), .SATURATE(0)) u_dut_c (
    .clock(clock), .rstn(rstn),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_chan(in_chan[2]), .in_data(in_data[2]),
    .clear(clear[2]), .out_valid(out_valid[2]), .out_chan(out_chan[2]), .out_sum(out_sum[2]),
    .err(err[2]), .ovf(ovf_c), .led(led_c), .busy(busy[2])
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_err;
    logic [1:0]  ch;
    logic [7:0]  sum;
    int unsigned cyc;
  } exp_t;

  exp_t sb_q0[$];
  exp_t sb_q1[$];
  exp_t sb_q2[$];

  int unsigned ncyc = 0;

  task automatic sb_push(input int d, input exp_t e);
    case (d)
      0:       sb_q0.push_back(e);
      1:       sb_q1.push_back(e);
      default: sb_q2.push_back(e);
    endcase
  endtask

  task automatic sb_check(input int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (d)
      0:       if (sb_q0.size() > 0) begin e = sb_q0.pop_front(); have = 1'b1; end
      1:       if (sb_q1.size() > 0) begin e = sb_q1.pop_front(); have = 1'b1; end
      default: if (sb_q2.size() > 0) begin e = sb_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_unexpected dut%0d: out_valid=%0b err=%0b chan=%0d sum=%0d, no beat expected",
               d, out_valid[d], err[d], out_chan[d], out_sum[d]);
      return;
    end
    check($sformatf("sb_err dut%0d", d),       32'(err[d]),       32'(e.is_err));
    check($sformatf("sb_out_valid dut%0d", d), 32'(out_valid[d]), 32'(!e.is_err));
    check($sformatf("sb_cycle dut%0d", d),     ncyc,              e.cyc);
    if (!e.is_err) begin
      check($sformatf("sb_chan dut%0d", d), 32'(out_chan[d]), 32'(e.ch));
      check($sformatf("sb_sum dut%0d", d),  32'(out_sum[d]),  32'(e.sum));
    end
  endtask

  always @(negedge clock) begin
    ncyc++;
    if (rstn) begin
      for (int d = 0; d < NDUT; d++) begin
        if (out_valid[d] || err[d]) sb_check(d);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver: call at a negedge; leaves in_valid high and returns at the negedge
  // after acceptance so beats can be issued back to back.
  // ---------------------------------------------------------------------------
  task automatic send(input int d, input logic [1:0] ch, input logic [7:0] data,
                      input bit is_err, input logic [7:0] exp_sum, output int waited);
    exp_t e;
    in_valid[d] = 1'b1;
    in_chan[d]  = ch;
    in_data[d]  = data;
    #1;
    waited = 0;
    while (!in_ready[d] && waited < 50) begin
      @(negedge clock);
      #1;
      waited++;
    end
    if (!in_ready[d]) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout dut%0d: in_ready low for %0d cycles, required high", d, waited);
      in_valid[d] = 1'b0;
      return;
    end
    e.is_err = is_err;
    e.ch     = ch;
    e.sum    = exp_sum;
    e.cyc    = ncyc + 2;
    sb_push(d, e);
    @(negedge clock);
  endtask

  task automatic drop_and_idle(input int d, input int n);
    in_valid[d] = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int nb;

    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0;
      in_chan[d]  = '0;
      in_data[d]  = '0;
      clear[d]    = 1'b0;
    end
    rstn = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_in_ready dut%0d", d),  32'(in_ready[d]),  0);
      check($sformatf("rst_out_valid dut%0d", d), 32'(out_valid[d]), 0);
      check($sformatf("rst_err dut%0d", d),       32'(err[d]),       0);
      check($sformatf("rst_busy dut%0d", d),      32'(busy[d]),      0);
      check($sformatf("rst_out_sum dut%0d", d),   32'(out_sum[d]),   0);
    end
    check("rst_ovf_a", 32'(ovf_a), 0);
    check("rst_led_a", 32'(led_a), 0);
    check("rst_ovf_c", 32'(ovf_c), 0);
    check("rst_led_c", 32'(led_c), 0);

    rstn = 1'b1;
    #1;
    check("ready_before_first_edge", 32'(in_ready[0]), 0);
    @(negedge clock);
    #1;
    for (int d = 0; d < NDUT; d++) check($sformatf("ready_after_release dut%0d", d), 32'(in_ready[d]), 1);
    @(negedge clock);

    // Consecutive adds to channel 2
    send(0, 2'd2, 8'd3, 1'b0, 8'd3, w);
    send(0, 2'd2, 8'd5, 1'b0, 8'd8, w);
    drop_and_idle(0, 3);
    check("a_ovf_after_small_adds", 32'(ovf_a), 0);
    check("a_led_after_small_adds", 32'(led_a), 0);

    // Wrap on channel 1: 200 + 100 = 300 -> 44
    send(0, 2'd1, 8'd200, 1'b0, 8'd200, w);
    send(0, 2'd1, 8'd100, 1'b0, 8'd44,  w);
    drop_and_idle(0, 3);
    check("a_ovf_wrap", 32'(ovf_a), 32'h2);
    check("a_led_wrap", 32'(led_a), 32'h0);

    // Saturate on channel 1: clamps at 255
    send(1, 2'd1, 8'd200, 1'b0, 8'd200, w);
    send(1, 2'd1, 8'd100, 1'b0, 8'd255, w);
    drop_and_idle(1, 3);
    check("b_ovf_sat", 32'(ovf_b), 32'h2);
    check("b_led_sat", 32'(led_b), 32'h2);

    // Ten back-to-back beats on channel 0
    for (int i = 1; i <= 10; i++) begin
      send(0, 2'd0, 8'd1, 1'b0, 8'(i), w);
      check($sformatf("a_stream_ready beat%0d", i), 32'(w), 0);
    end
    drop_and_idle(0, 3);

    // Clear sweep with a beat in stage 1 and a held beat behind it
    send(0, 2'd3, 8'd9, 1'b0, 8'd9, w);
    in_chan[0] = 2'd3;
    in_data[0] = 8'd4;
    clear[0]   = 1'b1;
    #1;
    check("a_ready_in_clear_cycle", 32'(in_ready[0]), 0);
    @(negedge clock);
    clear[0] = 1'b0;
    #1;
    nb = 0;
    while (busy[0] && nb < 20) begin
      nb++;
      check($sformatf("a_ready_while_busy cyc%0d", nb), 32'(in_ready[0]), 0);
      @(negedge clock);
      #1;
    end
    check("a_busy_cycles", 32'(nb), 4);
    check("a_ovf_after_clear", 32'(ovf_a), 0);
    send(0, 2'd3, 8'd4, 1'b0, 8'd4, w);
    check("a_held_accept_first_cycle", 32'(w), 0);
    send(0, 2'd0, 8'd0, 1'b0, 8'd0, w);
    send(0, 2'd1, 8'd0, 1'b0, 8'd0, w);
    send(0, 2'd2, 8'd0, 1'b0, 8'd0, w);
    drop_and_idle(0, 3);
    check("a_led_after_clear", 32'(led_a), 0);

    // Invalid channel on the 3-channel bank; START_VALUE truncates to 5
    send(2, 2'd3, 8'd7, 1'b1, 8'd0, w);
    send(2, 2'd0, 8'd0, 1'b0, 8'd5, w);
    send(2, 2'd1, 8'd0, 1'b0, 8'd5, w);
    send(2, 2'd2, 8'd0, 1'b0, 8'd5, w);
    drop_and_idle(2, 3);
    check("c_ovf_after_err", 32'(ovf_c), 0);
    check("c_led_after_err", 32'(led_c), 0);
    send(2, 2'd0, 8'd200, 1'b0, 8'd205, w);
    drop_and_idle(2, 3);
    check("c_led_msb", 32'(led_c), 32'h1);

    // Reset in the middle of a sweep
    clear[2] = 1'b1;
    @(negedge clock);
    clear[2] = 1'b0;
    #1;
    check("c_busy_sweep", 32'(busy[2]), 1);
    @(negedge clock);
    #3;
    rstn = 1'b0;
    #1;
    check("c_rst_busy",      32'(busy[2]),      0);
    check("c_rst_in_ready",  32'(in_ready[2]),  0);
    check("c_rst_out_valid", 32'(out_valid[2]), 0);
    check("c_rst_err",       32'(err[2]),       0);
    check("c_rst_out_sum",   32'(out_sum[2]),   0);
    check("c_rst_out_chan",  32'(out_chan[2]),  0);
    check("c_rst_led",       32'(led_c),        0);
    check("c_rst_ovf",       32'(ovf_c),        0);
    repeat (2) @(negedge clock);

    check("sb_drained dut0", sb_q0.size(), 0);
    check("sb_drained dut1", sb_q1.size(), 0);
    check("sb_drained dut2", sb_q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
